// File: rtl/ltssm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ltssm_pkg
//  Description : Shared symbol constants and lane-FSM state type for the
//                LTSSM TS1/TS2 ordered-set decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ltssm_pkg;

    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] PAD      = 8'hF7;
    localparam logic [7:0] TS1_ID   = 8'h4A;
    localparam logic [7:0] TS2_ID   = 8'h45;
    localparam logic [7:0] TS1_INV  = 8'hB5;
    localparam logic [7:0] TS2_INV  = 8'hBA;
    localparam logic [7:0] IDLE_SYM = 8'h00;

    localparam logic [3:0] SYM_LINK     = 4'd1;
    localparam logic [3:0] SYM_LANE     = 4'd2;
    localparam logic [3:0] SYM_NFTS     = 4'd3;
    localparam logic [3:0] SYM_RATE     = 4'd4;
    localparam logic [3:0] SYM_CTRL     = 4'd5;
    localparam logic [3:0] SYM_ID_FIRST = 4'd6;
    localparam logic [3:0] SYM_LAST     = 4'd15;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FIELD = 2'd1,
        IDENT = 2'd2
    } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/ts_lane_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ts_lane_decoder
//  Description : One lane of the TS1/TS2 decoder: ordered-set FSM, shadow
//                field capture, idle-run counter and registered outputs.
//                Optional: LTSSM_TS_POLARITY_DETECT_EN (inverted TS detect).
//  Revision    : 1.0 - initial release
// ============================================================================
module ts_lane_decoder
    import ltssm_pkg::*;
#(
    parameter int IDLE_COUNT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       sym_vld_i,
    input  logic [7:0] sym_i,
    input  logic       is_k_i,
    output logic       ts1_valid_o,
    output logic       ts2_valid_o,
    output logic       idle_valid_o,
    output logic       ts_error_o,
    output logic       link_pad_o,
    output logic       lane_pad_o,
    output logic [7:0] link_num_o,
    output logic [7:0] lane_num_o,
    output logic [7:0] n_fts_o,
    output logic [7:0] rate_id_o,
    output logic [7:0] training_ctrl_o
`ifdef LTSSM_TS_POLARITY_DETECT_EN
    ,
    output logic       rx_polarity_inv_o
`endif
);

    localparam logic [7:0] c_IDLE_MAX = 8'(IDLE_COUNT);

    lane_state_t state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_d, done_d;
    logic [7:0]  sh_link_q, sh_lane_q, sh_nfts_q, sh_rate_q, sh_ctrl_q;
    logic        sh_lpad_q, sh_npad_q;
    logic        ts1_q, ts2_q, idle_q, err_q, lpad_q, npad_q;
    logic [7:0]  link_q, lane_q, nfts_q, rate_q, ctrl_q;

    logic w_com, w_pad, w_id_ok, w_good;
    assign w_com = is_k_i && (sym_i == COM);
    assign w_pad = is_k_i && (sym_i == PAD);
`ifdef LTSSM_TS_POLARITY_DETECT_EN
    logic pol_q;
    assign w_id_ok = !is_k_i && (sym_i == TS1_ID || sym_i == TS2_ID ||
                                 sym_i == TS1_INV || sym_i == TS2_INV);
    assign rx_polarity_inv_o = pol_q;
`else
    assign w_id_ok = !is_k_i && (sym_i == TS1_ID || sym_i == TS2_ID);
`endif
    assign w_good = done_d && (id_q == TS1_ID || id_q == TS2_ID);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        if (sym_vld_i) begin
            if (!is_k_i && sym_i == IDLE_SYM)
                cnt_d = (cnt_q == c_IDLE_MAX) ? cnt_q : cnt_q + 8'd1;
            else
                cnt_d = 8'd0;
            // COM always (re)starts a set; it is only an error mid-set
            if (w_com) begin
                state_d = FIELD;
                idx_d   = SYM_LINK;
                err_d   = (state_q != HUNT);
            end else begin
                case (state_q)
                    FIELD: begin
                        if (!is_k_i || (w_pad && idx_q <= SYM_LANE)) begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == SYM_CTRL)
                                state_d = IDENT;
                        end else begin
                            state_d = HUNT;
                            err_d   = 1'b1;
                        end
                    end
                    IDENT: begin
                        if (idx_q == SYM_ID_FIRST) begin
                            if (w_id_ok) begin
                                id_d  = sym_i;
                                idx_d = idx_q + 4'd1;
                            end else begin
                                state_d = HUNT;
                                err_d   = 1'b1;
                            end
                        end else if (!is_k_i && sym_i == id_q) begin
                            if (idx_q == SYM_LAST) begin
                                state_d = HUNT;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end else begin
                            state_d = HUNT;
                            err_d   = 1'b1;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q   <= HUNT;
            idx_q     <= 4'd0;
            id_q      <= 8'd0;
            cnt_q     <= 8'd0;
            sh_link_q <= 8'd0;
            sh_lane_q <= 8'd0;
            sh_nfts_q <= 8'd0;
            sh_rate_q <= 8'd0;
            sh_ctrl_q <= 8'd0;
            sh_lpad_q <= 1'b0;
            sh_npad_q <= 1'b0;
            ts1_q     <= 1'b0;
            ts2_q     <= 1'b0;
            idle_q    <= 1'b0;
            err_q     <= 1'b0;
            lpad_q    <= 1'b0;
            npad_q    <= 1'b0;
            link_q    <= 8'd0;
            lane_q    <= 8'd0;
            nfts_q    <= 8'd0;
            rate_q    <= 8'd0;
            ctrl_q    <= 8'd0;
`ifdef LTSSM_TS_POLARITY_DETECT_EN
            pol_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            idle_q  <= (cnt_d == c_IDLE_MAX);
            err_q   <= err_d;
            ts1_q   <= done_d && (id_q == TS1_ID);
            ts2_q   <= done_d && (id_q == TS2_ID);
            if (sym_vld_i && state_q == FIELD && !w_com) begin
                case (idx_q)
                    SYM_LINK: begin sh_link_q <= sym_i; sh_lpad_q <= w_pad; end
                    SYM_LANE: begin sh_lane_q <= sym_i; sh_npad_q <= w_pad; end
                    SYM_NFTS: sh_nfts_q <= sym_i;
                    SYM_RATE: sh_rate_q <= sym_i;
                    SYM_CTRL: sh_ctrl_q <= sym_i;
                    default:  sh_ctrl_q <= sh_ctrl_q;
                endcase
            end
            // Visible fields only change when a whole set has been verified
            if (w_good) begin
                link_q <= sh_link_q;
                lane_q <= sh_lane_q;
                nfts_q <= sh_nfts_q;
                rate_q <= sh_rate_q;
                ctrl_q <= sh_ctrl_q;
                lpad_q <= sh_lpad_q;
                npad_q <= sh_npad_q;
            end
`ifdef LTSSM_TS_POLARITY_DETECT_EN
            if (done_d && (id_q == TS1_INV || id_q == TS2_INV))
                pol_q <= 1'b1;
`endif
        end
    end

    assign ts1_valid_o     = ts1_q;
    assign ts2_valid_o     = ts2_q;
    assign idle_valid_o    = idle_q;
    assign ts_error_o      = err_q;
    assign link_pad_o      = lpad_q;
    assign lane_pad_o      = npad_q;
    assign link_num_o      = link_q;
    assign lane_num_o      = lane_q;
    assign n_fts_o         = nfts_q;
    assign rate_id_o       = rate_q;
    assign training_ctrl_o = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/ltssm_ts_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ltssm_ts_decoder
//  Description : Multi-lane receive TS1/TS2/idle decoder on a byte-striped
//                AXI-stream. Optional: LTSSM_TS_POLARITY_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltssm_ts_decoder
    import ltssm_pkg::*;
#(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = MAX_NUM_LANES * 8,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = DATA_WIDTH / 8,
    parameter int IDLE_COUNT    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep_i,
    input  logic                       s_axis_tvalid_i,
    input  logic                       s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser_i,
    output logic                       s_axis_tready_o,
    output logic [MAX_NUM_LANES-1:0]   ts1_valid_o,
    output logic [MAX_NUM_LANES-1:0]   ts2_valid_o,
    output logic [MAX_NUM_LANES-1:0]   idle_valid_o,
    output logic [MAX_NUM_LANES*8-1:0] link_num_o,
    output logic [MAX_NUM_LANES*8-1:0] lane_num_o,
    output logic [MAX_NUM_LANES-1:0]   link_pad_o,
    output logic [MAX_NUM_LANES-1:0]   lane_pad_o,
    output logic [MAX_NUM_LANES*8-1:0] n_fts_o,
    output logic [MAX_NUM_LANES*8-1:0] rate_id_o,
    output logic [MAX_NUM_LANES*8-1:0] training_ctrl_o,
`ifdef LTSSM_TS_POLARITY_DETECT_EN
    output logic [MAX_NUM_LANES-1:0]   rx_polarity_inv_o,
`endif
    output logic [MAX_NUM_LANES-1:0]   ts_error_o
);

    logic tready_q;
    logic w_unused_tlast;
    assign w_unused_tlast = s_axis_tlast_i;

    // Never back-pressures, so the stream drains even while disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) tready_q <= 1'b0;
        else       tready_q <= 1'b1;
    end
    assign s_axis_tready_o = tready_q;

    generate
        for (genvar l = 0; l < MAX_NUM_LANES; l++) begin : g_lane
            ts_lane_decoder #(
                .IDLE_COUNT (IDLE_COUNT)
            ) u_lane (
                .clk_i           (clk_i),
                .rst_i           (rst_i),
                .en_i            (en_i),
                .sym_vld_i       (s_axis_tvalid_i & s_axis_tkeep_i[l]),
                .sym_i           (s_axis_tdata_i[l*8 +: 8]),
                .is_k_i          (s_axis_tuser_i[l]),
                .ts1_valid_o     (ts1_valid_o[l]),
                .ts2_valid_o     (ts2_valid_o[l]),
                .idle_valid_o    (idle_valid_o[l]),
                .ts_error_o      (ts_error_o[l]),
                .link_pad_o      (link_pad_o[l]),
                .lane_pad_o      (lane_pad_o[l]),
                .link_num_o      (link_num_o[l*8 +: 8]),
                .lane_num_o      (lane_num_o[l*8 +: 8]),
                .n_fts_o         (n_fts_o[l*8 +: 8]),
                .rate_id_o       (rate_id_o[l*8 +: 8]),
`ifdef LTSSM_TS_POLARITY_DETECT_EN
                .rx_polarity_inv_o (rx_polarity_inv_o[l]),
`endif
                .training_ctrl_o (training_ctrl_o[l*8 +: 8])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ltssm_ts_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ltssm_ts_decoder
//  Description : Self-checking bench for ltssm_ts_decoder against a
//                queue-based symbol-parsing reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ltssm_ts_decoder;

    localparam int IDLE_COUNT = 8;
`ifdef LTSSM_TS_POLARITY_DETECT_EN
    localparam bit POL = 1'b1;
`else
    localparam bit POL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [3:0]  tuser = '0;
    logic        tready;
    logic [3:0]  ts1_v, ts2_v, idle_v, lpad_v, npad_v, err_v;
    logic [31:0] link_v, lane_v, nfts_v, rate_v, ctrl_v;
`ifdef LTSSM_TS_POLARITY_DETECT_EN
    logic [3:0]  pol_v;
`endif

    always #5 clk = ~clk;

    ltssm_ts_decoder #(.MAX_NUM_LANES(4), .IDLE_COUNT(IDLE_COUNT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .s_axis_tdata_i  (tdata),
        .s_axis_tkeep_i  (tkeep),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tlast_i  (tlast),
        .s_axis_tuser_i  (tuser),
        .s_axis_tready_o (tready),
        .ts1_valid_o     (ts1_v),
        .ts2_valid_o     (ts2_v),
        .idle_valid_o    (idle_v),
        .link_num_o      (link_v),
        .lane_num_o      (lane_v),
        .link_pad_o      (lpad_v),
        .lane_pad_o      (npad_v),
        .n_fts_o         (nfts_v),
        .rate_id_o       (rate_v),
        .training_ctrl_o (ctrl_v),
`ifdef LTSSM_TS_POLARITY_DETECT_EN
        .rx_polarity_inv_o (pol_v),
`endif
        .ts_error_o      (err_v)
    );

    logic [184:0] obs;
    assign obs = {tready, ts1_v, ts2_v, err_v, idle_v, lpad_v, npad_v,
                  link_v, lane_v, nfts_v, rate_v, ctrl_v};

    int checks = 0;
    int failures = 0;

    // Reference model: per-lane list of symbols collected since the last COM
    logic [8:0]  fr [4][16];
    int          flen [4];
    int          run [4];
    logic        m_rdy = 1'b0;
    logic [3:0]  m_ts1 = '0, m_ts2 = '0, m_err = '0, m_idle = '0;
    logic [3:0]  m_lpad = '0, m_npad = '0, m_pol = '0;
    logic [31:0] m_link = '0, m_lane = '0, m_nfts = '0, m_rate = '0, m_ctrl = '0;

    // Stimulus: per-lane symbol buffers ({K, byte})
    logic [8:0]  lbuf [4][64];
    int          lhead [4];
    int          llen [4];

    function automatic logic [184:0] expv();
        return {m_rdy, m_ts1, m_ts2, m_err, m_idle, m_lpad, m_npad,
                m_link, m_lane, m_nfts, m_rate, m_ctrl};
    endfunction

    function automatic bit sym_ok(int pos, logic [8:0] s, logic [7:0] id);
        if (pos <= 2) return !s[8] || s[7:0] == 8'hF7;
        if (pos <= 5) return !s[8];
        if (pos == 6) return !s[8] && (s[7:0] == 8'h4A || s[7:0] == 8'h45 ||
                                       (POL && (s[7:0] == 8'hB5 || s[7:0] == 8'hBA)));
        return !s[8] && s[7:0] == id;
    endfunction

    task automatic mclear();
        for (int l = 0; l < 4; l++) begin flen[l] = 0; run[l] = 0; end
        m_idle = '0; m_lpad = '0; m_npad = '0; m_pol = '0;
        m_link = '0; m_lane = '0; m_nfts = '0; m_rate = '0; m_ctrl = '0;
    endtask

    task automatic mstep(input logic vld, input logic [3:0] keep, input logic [31:0] data,
                         input logic [3:0] user, input logic en_s, input logic rst_s);
        logic [8:0] s;
        m_ts1 = '0; m_ts2 = '0; m_err = '0;
        if (rst_s) begin
            m_rdy = 1'b0;
            mclear();
        end else if (!en_s) begin
            m_rdy = 1'b1;
            mclear();
        end else begin
            m_rdy = 1'b1;
            for (int l = 0; l < 4; l++) begin
                if (vld && keep[l]) begin
                    s = {user[l], data[l*8 +: 8]};
                    if (s == 9'h000) begin if (run[l] < 1000) run[l]++; end
                    else run[l] = 0;
                    if (s == 9'h1BC) begin
                        if (flen[l] != 0) m_err[l] = 1'b1;
                        fr[l][0] = s;
                        flen[l] = 1;
                    end else if (flen[l] != 0) begin
                        if (!sym_ok(flen[l], s, fr[l][6][7:0])) begin
                            m_err[l] = 1'b1;
                            flen[l] = 0;
                        end else begin
                            fr[l][flen[l]] = s;
                            flen[l]++;
                            if (flen[l] == 16) begin
                                flen[l] = 0;
                                if (fr[l][6][7:0] == 8'h4A || fr[l][6][7:0] == 8'h45) begin
                                    if (fr[l][6][7:0] == 8'h4A) m_ts1[l] = 1'b1;
                                    else                        m_ts2[l] = 1'b1;
                                    m_link[l*8 +: 8] = fr[l][1][7:0];
                                    m_lpad[l]        = fr[l][1][8];
                                    m_lane[l*8 +: 8] = fr[l][2][7:0];
                                    m_npad[l]        = fr[l][2][8];
                                    m_nfts[l*8 +: 8] = fr[l][3][7:0];
                                    m_rate[l*8 +: 8] = fr[l][4][7:0];
                                    m_ctrl[l*8 +: 8] = fr[l][5][7:0];
                                end else begin
                                    m_pol[l] = 1'b1;
                                end
                            end
                        end
                    end
                end
                m_idle[l] = (run[l] >= IDLE_COUNT);
            end
        end
    endtask

    task automatic beat(input logic vld, input logic [3:0] keep,
                        input logic [31:0] data, input logic [3:0] user);
        tvalid = vld; tkeep = keep; tdata = data; tuser = user;
        tlast = 1'($urandom_range(0, 1));
        @(posedge clk);
        mstep(vld, keep, data, user, en, rst);
        #1;
    endtask

    function automatic bit pending();
        for (int l = 0; l < 4; l++) if (lhead[l] < llen[l]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_next(input logic vld, input logic [3:0] mask);
        logic [3:0]  keep = '0;
        logic [31:0] data = $urandom;
        logic [3:0]  user = 4'($urandom);
        for (int l = 0; l < 4; l++) begin
            if (lhead[l] < llen[l] && mask[l]) begin
                keep[l] = 1'b1;
                data[l*8 +: 8] = lbuf[l][lhead[l]][7:0];
                user[l] = lbuf[l][lhead[l]][8];
                if (vld) lhead[l]++;
            end
        end
        beat(vld, keep, data, user);
    endtask

    task automatic clear_bufs();
        for (int l = 0; l < 4; l++) begin lhead[l] = 0; llen[l] = 0; end
    endtask

    task automatic push(int l, logic [8:0] s);
        lbuf[l][llen[l]] = s;
        llen[l]++;
    endtask

    task automatic push_ts(int l, logic [8:0] link, logic [8:0] lane, logic [7:0] nfts,
                           logic [7:0] rate, logic [7:0] ctrl, logic [7:0] id);
        push(l, 9'h1BC); push(l, link); push(l, lane);
        push(l, {1'b0, nfts}); push(l, {1'b0, rate}); push(l, {1'b0, ctrl});
        repeat (10) push(l, {1'b0, id});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 4'h0, 32'h0, 4'h0);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_state act=%h exp=0", obs);
            end
        end
        rst = 1'b0;
        beat(1'b0, 4'h0, 32'h0, 4'h0);
        checks++;
        if (tready !== 1'b1 || obs !== expv()) begin
            failures++;
            $display("FAIL reset_release act=%h exp=%h", obs, expv());
        end
    endtask

    task automatic test_ts1_all_lanes();
        logic [3:0] seen_after;
        clear_bufs();
        for (int l = 0; l < 4; l++)
            push_ts(l, 9'h005, 9'(l), 8'h10, 8'h02, 8'h00, 8'h4A);
        while (pending()) begin
            drive_next(1'b1, 4'hF);
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL ts1_all act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (ts1_v !== 4'hF || lane_v !== 32'h03020100 || link_v !== 32'h05050505) begin
            failures++;
            $display("FAIL ts1_fields ts1=%h lane=%h link=%h exp F/03020100/05050505",
                     ts1_v, lane_v, link_v);
        end
        beat(1'b0, 4'h0, 32'h0, 4'h0);
        seen_after = ts1_v;
        checks++;
        if (seen_after !== 4'h0) begin
            failures++;
            $display("FAIL ts1_one_cycle act=%h exp=0", seen_after);
        end
    endtask

    task automatic test_ts2_pad();
        clear_bufs();
        push_ts(2, 9'h1F7, 9'h1F7, 8'h20, 8'h02, 8'h01, 8'h45);
        while (pending()) begin
            drive_next(1'b1, 4'hF);
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL ts2_pad act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (ts2_v !== 4'b0100 || lpad_v !== 4'b0100 || npad_v !== 4'b0100 ||
            lane_v[31:24] !== 8'h03 || lane_v[15:0] !== 16'h0100) begin
            failures++;
            $display("FAIL ts2_pad_fields ts2=%h lpad=%h npad=%h lane=%h", ts2_v, lpad_v, npad_v, lane_v);
        end
    endtask

    task automatic test_abort_ident();
        clear_bufs();
        push(0, 9'h1BC); push(0, 9'h077); push(0, 9'h066); push(0, 9'h010);
        push(0, 9'h002); push(0, 9'h000);
        repeat (5) push(0, 9'h04A);
        push(0, 9'h045);
        while (pending()) begin
            drive_next(1'b1, 4'hF);
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL abort act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (err_v !== 4'b0001 || ts1_v !== 4'h0 || link_v[7:0] !== 8'h05 || lane_v[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL abort_fields err=%h ts1=%h link=%h lane=%h exp 1/0/05/00",
                     err_v, ts1_v, link_v[7:0], lane_v[7:0]);
        end
    endtask

    task automatic test_com_restart();
        int n_err = 0;
        int n_ts1 = 0;
        clear_bufs();
        push(1, 9'h1BC); push(1, 9'h005); push(1, 9'h001); push(1, 9'h010);
        push(1, 9'h002); push(1, 9'h000);
        repeat (3) push(1, 9'h04A);
        push_ts(1, 9'h005, 9'h007, 8'h10, 8'h02, 8'h00, 8'h4A);
        while (pending()) begin
            drive_next(1'b1, 4'hF);
            if (err_v[1]) n_err++;
            if (ts1_v[1]) n_ts1++;
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL com_restart act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (n_err != 1 || n_ts1 != 1 || lane_v[15:8] !== 8'h07) begin
            failures++;
            $display("FAIL com_restart_count err=%0d ts1=%0d lane=%h exp 1/1/07", n_err, n_ts1, lane_v[15:8]);
        end
    endtask

    task automatic test_idle();
        clear_bufs();
        repeat (7) push(3, 9'h000);
        push(3, 9'h001);
        while (pending()) begin
            drive_next(1'b1, 4'hF);
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL idle_short act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (idle_v[3] !== 1'b0) begin
            failures++;
            $display("FAIL idle_seven act=%b exp=0", idle_v[3]);
        end
        clear_bufs();
        repeat (8) push(3, 9'h000);
        while (pending()) begin
            drive_next(1'b1, 4'hF);
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL idle_run act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (idle_v[3] !== 1'b1) begin
            failures++;
            $display("FAIL idle_eight act=%b exp=1", idle_v[3]);
        end
    endtask

    task automatic test_gaps_and_enable();
        logic [3:0] seen = '0;
        int n = 0;
        clear_bufs();
        for (int l = 0; l < 4; l++)
            push_ts(l, 9'h009, 9'(8'h0A + 8'(l)), 8'h11, 8'h02, 8'h00, 8'h4A);
        while (pending() && n < 200) begin
            drive_next(1'(n % 2), 4'hF);
            n++;
            seen |= ts1_v;
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL gaps act=%h exp=%h", obs, expv());
            end
        end
        checks++;
        if (seen !== 4'hF || lane_v !== 32'h0D0C0B0A) begin
            failures++;
            $display("FAIL gaps_result seen=%h lane=%h exp F/0D0C0B0A", seen, lane_v);
        end
        clear_bufs();
        seen = '0;
        n = 0;
        for (int l = 0; l < 4; l++)
            push_ts(l, 9'h009, 9'h001, 8'h11, 8'h02, 8'h00, 8'h4A);
        while (pending() && n < 200) begin
            en = (n == 8) ? 1'b0 : 1'b1;
            drive_next(1'b1, 4'hF);
            n++;
            seen |= ts1_v;
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL en_drop act=%h exp=%h", obs, expv());
            end
        end
        en = 1'b1;
        checks++;
        if (seen !== 4'h0 || link_v !== 32'h0 || lane_v !== 32'h0) begin
            failures++;
            $display("FAIL en_drop_result seen=%h link=%h lane=%h exp 0/0/0", seen, link_v, lane_v);
        end
    endtask

    task automatic refill(int l);
        int c, start, p;
        logic [8:0] lk, ln;
        lhead[l] = 0;
        llen[l] = 0;
        c = $urandom_range(0, 3);
        if (c == 2) begin
            repeat ($urandom_range(1, 12)) push(l, 9'h000);
        end else begin
            start = llen[l];
            lk = ($urandom_range(0, 3) == 0) ? 9'h1F7 : {1'b0, 8'($urandom)};
            ln = ($urandom_range(0, 3) == 0) ? 9'h1F7 : {1'b0, 8'($urandom)};
            push_ts(l, lk, ln, 8'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 1) == 1) ? 8'h45 : 8'h4A);
            if (c == 3) begin
                p = $urandom_range(1, 15);
                case ($urandom_range(0, 2))
                    0:       lbuf[l][start + p] = {1'($urandom_range(0, 1)), 8'($urandom)};
                    1:       lbuf[l][start + p] = 9'h1BC;
                    default: lbuf[l][start + p] = {1'b0, (p == 6) ? 8'hB5 : 8'hF7};
                endcase
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        clear_bufs();
        for (int i = 0; i < 1500; i++) begin
            for (int l = 0; l < 4; l++) if (lhead[l] >= llen[l]) refill(l);
            for (int l = 0; l < 4; l++) mask[l] = ($urandom_range(0, 4) != 0);
            en = ($urandom_range(0, 199) != 0);
            drive_next($urandom_range(0, 3) != 0, mask);
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL random beat=%0d act=%h exp=%h", i, obs, expv());
            end
`ifdef LTSSM_TS_POLARITY_DETECT_EN
            checks++;
            if (pol_v !== m_pol) begin
                failures++;
                $display("FAIL polarity beat=%0d act=%h exp=%h", i, pol_v, m_pol);
            end
`endif
        end
        en = 1'b1;
    endtask

    initial begin
        clear_bufs();
        for (int l = 0; l < 4; l++) begin flen[l] = 0; run[l] = 0; end
        test_reset();
        test_ts1_all_lanes();
        test_ts2_pad();
        test_abort_ident();
        test_com_restart();
        test_idle();
        test_gaps_and_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
